// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control unit.
// Holds the sequencer states, ALU/mux encodings and the ALU command decode.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic [1:0] ctl;
    logic       nowrite;
    logic       known;
    logic       cmp;
    logic       logic_op;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    d = '{ctl: ALU_ADD, nowrite: 1'b1, known: 1'b0,
          cmp: 1'b0, logic_op: 1'b0};
    unique case (cmd)
      CMD_ADD: d = '{ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0};
      CMD_SUB: d = '{ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0};
      CMD_AND: d = '{ALU_AND, 1'b0, 1'b1, 1'b0, 1'b1};
      CMD_ORR: d = '{ALU_ORR, 1'b0, 1'b1, 1'b0, 1'b1};
      CMD_CMP: d = '{ALU_SUB, 1'b1, 1'b1, 1'b1, 1'b0};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_eval.sv
// Condition-field evaluator: Cond against the stored NZCV flags.
// Purely combinational; 1110/1111 always pass.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v, ge;

  assign {n, z, c, v} = flags_i;
  assign ge = (n == v);

  always_comb begin
    cond_ex_o = 1'b1;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~(c & ~z);
      COND_GE: cond_ex_o = ge;
      COND_LT: cond_ex_o = ~ge;
      COND_GT: cond_ex_o = ~z & ge;
      COND_LE: cond_ex_o = ~(~z & ge);
      default: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main sequencer: owns NZCV flags and gates every
// architectural write with the instruction's condition result.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags
);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       pc_w, mem_w, reg_w, ir_w;
  logic       rd_is_pc;
  alu_dec_t   dec;

  cond_eval u_cond (
    .cond_i    (Cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  assign dec      = alu_decode(Funct[4:1]);
  assign rd_is_pc = (Rd == PC_REG);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RM;
    ALUControl = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        unique case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = cond_ex;
        pc_w      = cond_ex & rd_is_pc;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        mem_w   = cond_ex;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RM;
        ALUControl = dec.ctl;
        // Logic ops leave C and V alone
        if (cond_ex && dec.known && (Funct[0] || dec.cmp)) begin
          flags_d = dec.logic_op ? {ALUFlags[3:2], flags_q[1:0]}
                                 : ALUFlags;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = cond_ex & ~dec.nowrite;
        pc_w    = cond_ex & ~dec.nowrite & rd_is_pc;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        pc_w      = cond_ex;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PCWrite  = pc_w & rst_n;
  assign MemWrite = mem_w & rst_n;
  assign RegWrite = reg_w & rst_n;
  assign IRWrite  = ir_w & rst_n;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign Flags    = flags_q;

endmodule
